// File: rtl/fp_operand_loader.sv
// fp_operand_loader: builds the two 32-bit FP adder operands from an 8-bit
// switch bank and a single bouncy push-button. The button is synchronised and
// debounced, and each accepted press loads one byte, MSB first: A0..A3, then
// B0..B3. reg_A/reg_B are updated together on the eighth press and flagged by a
// one-cycle operands_valid pulse.
//
// Handshake: operands_valid is a push-only strobe with no ready. It is high for
// exactly one cycle, the cycle in which reg_A/reg_B first show the new pair. The
// consumer must take the pair in that cycle or read the held registers later.
module fp_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        noisy_level,
    input  logic [7:0]  sw,
    output logic [31:0] reg_A,
    output logic [31:0] reg_B,
    output logic        operands_valid,
    output logic        entry_sel,
    output logic [1:0]  byte_idx,
    output logic        press
);

    // Terminal count: deb takes the new level on this count.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTER  = 2'd0,
        COMMIT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic              sync_1;
    logic              sync_2;
    logic              deb;
    logic              deb_d;
    logic [CNT_W-1:0]  deb_cnt;
    logic [31:0]       shadow_a;
    logic [31:0]       shadow_b;

    // Byte k of a word is bits [31-8k : 24-8k]; byte 0 is the MSB.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  k,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (k)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= noisy_level;
            sync_2 <= sync_1;
        end
    end

    // Debounce: deb adopts sync_2 only after DEBOUNCE_CYCLES consecutive
    // mismatching cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (sync_2 == deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_LAST) begin
            deb     <= sync_2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    // Rising-edge detect on the debounced level; releases produce nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_d <= 1'b0;
            press <= 1'b0;
        end else begin
            deb_d <= deb;
            press <= deb & ~deb_d;
        end
    end

    // Entry sequencer: loads shadow bytes on each press and commits both
    // operands atomically on the last B byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ENTER;
            reg_A          <= '0;
            reg_B          <= '0;
            shadow_a       <= '0;
            shadow_b       <= '0;
            operands_valid <= 1'b0;
            entry_sel      <= 1'b0;
            byte_idx       <= 2'd0;
        end else begin
            operands_valid <= 1'b0;
            case (state)
                ENTER: begin
                    if (press) begin
                        if (!entry_sel) begin
                            shadow_a <= put_byte(shadow_a, byte_idx, sw);
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                entry_sel <= 1'b1;
                            end
                        end else begin
                            shadow_b <= put_byte(shadow_b, byte_idx, sw);
                            if (byte_idx == 2'd3) begin
                                // The final byte is still in flight to the shadow,
                                // so splice it straight into reg_B.
                                reg_A          <= shadow_a;
                                reg_B          <= {shadow_b[31:8], sw};
                                operands_valid <= 1'b1;
                                entry_sel      <= 1'b0;
                                byte_idx       <= 2'd0;
                                state          <= COMMIT;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    entry_sel <= 1'b0;
                    byte_idx  <= 2'd0;
                    state     <= DONE;
                end
                DONE: begin
                    if (press) begin
                        shadow_a  <= put_byte(shadow_a, 2'd0, sw);
                        entry_sel <= 1'b0;
                        byte_idx  <= 2'd1;
                        state     <= ENTER;
                    end
                end
                default: begin
                    state <= ENTER;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_operand_loader.sv
// tb_fp_operand_loader: directed bench for fp_operand_loader with a short
// debounce window. A sample-history model predicts every output each cycle;
// literal checks pin the model to hand-computed operand values.
module tb_fp_operand_loader;

  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        noisy_level = 1'b0;
  logic [7:0]  sw = 8'h00;
  logic [31:0] reg_A;
  logic [31:0] reg_B;
  logic        operands_valid;
  logic        entry_sel;
  logic [1:0]  byte_idx;
  logic        press;

  always #5 clk = ~clk;

  fp_operand_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .noisy_level    (noisy_level),
    .sw             (sw),
    .reg_A          (reg_A),
    .reg_B          (reg_B),
    .operands_valid (operands_valid),
    .entry_sel      (entry_sel),
    .byte_idx       (byte_idx),
    .press          (press)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The button is described by its raw sample history. The debounced level
  // flips once the last D synchronised samples all disagree with it. Entry is
  // a position 0..7 into an 8-byte list.
  logic        samp_q[$];
  logic        deb_m;
  logic        rose_m;
  logic        press_m;
  logic        valid_m;
  logic        commit_m;
  logic        all_diff;
  int          pos_m;
  logic [7:0]  sh_m [8];
  logic [31:0] ra_m;
  logic [31:0] rb_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q.delete();
      repeat (D + 2) samp_q.push_back(1'b0);
      deb_m   = 1'b0;
      rose_m  = 1'b0;
      press_m = 1'b0;
      valid_m = 1'b0;
      pos_m   = 0;
      for (int k = 0; k < 8; k++) sh_m[k] = 8'h00;
      ra_m    = 32'h0;
      rb_m    = 32'h0;
    end else begin
      commit_m = 1'b0;
      if (press_m) begin
        sh_m[pos_m] = sw;
        if (pos_m == 7) begin
          ra_m     = {sh_m[0], sh_m[1], sh_m[2], sh_m[3]};
          rb_m     = {sh_m[4], sh_m[5], sh_m[6], sh_m[7]};
          pos_m    = 0;
          commit_m = 1'b1;
        end else begin
          pos_m = pos_m + 1;
        end
      end
      valid_m = commit_m;
      press_m = rose_m;
      // synchronised value seen now is the sample from two edges back
      all_diff = 1'b1;
      for (int k = 1; k <= D; k++)
        if (samp_q[samp_q.size() - 1 - k] == deb_m) all_diff = 1'b0;
      rose_m = 1'b0;
      if (all_diff) begin
        deb_m  = ~deb_m;
        rose_m = deb_m;
      end
      samp_q.push_back(noisy_level);
      if (samp_q.size() > D + 4) void'(samp_q.pop_front());
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("press", {31'd0, press}, {31'd0, press_m});
      check("operands_valid", {31'd0, operands_valid}, {31'd0, valid_m});
      check("entry_sel", {31'd0, entry_sel}, {31'd0, pos_m >= 4});
      check("byte_idx", {30'd0, byte_idx}, 32'(pos_m % 4));
      check("reg_A", reg_A, ra_m);
      check("reg_B", reg_B, rb_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_reg_A", reg_A, 32'h0);
    check("rst_reg_B", reg_B, 32'h0);
    check("rst_valid", {31'd0, operands_valid}, 32'h0);
    check("rst_press", {31'd0, press}, 32'h0);
    check("rst_entry_sel", {31'd0, entry_sel}, 32'h0);
    check("rst_byte_idx", {30'd0, byte_idx}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clean press. The press pulse lands D+3 cycles after the level rises;
  // with jitter, sw holds other values on the neighbouring cycles.
  task automatic do_press(input logic [7:0] b, input bit jitter, input bit exp_commit);
    @(negedge clk);
    noisy_level = 1'b1;
    sw = jitter ? 8'($urandom_range(0, 255)) : b;
    repeat (D + 2) @(negedge clk);
    if (jitter) sw = ~b;
    @(negedge clk);
    sw = b;
    check("press_cycle", {31'd0, press}, 32'h1);
    @(negedge clk);
    if (jitter) sw = ~b;
    check("commit_strobe", {31'd0, operands_valid}, {31'd0, exp_commit});
    repeat (2) @(negedge clk);
    noisy_level = 1'b0;
    repeat (D + 4) @(negedge clk);
    if (jitter) sw = 8'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] full_vec [8] = '{8'h2a, 8'hc4, 8'h92, 8'h14, 8'h6a, 8'hc4, 8'h92, 8'h14};
  int hits;
  int first_hit;

  initial begin
    // reset and idle
    reset_dut();
    cmp_en = 1'b1;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (press) hits++;
    end
    check("idle_press_count", 32'(hits), 32'd0);

    // bouncing input must not produce a press
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      noisy_level = ((i / 2) % 2) == 0;
      @(negedge clk);
      if (press) hits++;
    end
    check("bounce_press_count", 32'(hits), 32'd0);
    noisy_level = 1'b1;
    hits = 0;
    first_hit = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (press) begin
        hits++;
        first_hit = c;
      end
    end
    check("hold_press_count", 32'(hits), 32'd1);
    check("hold_press_latency", 32'(first_hit), 32'd7);
    noisy_level = 1'b0;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (press) hits++;
    end
    check("release_press_count", 32'(hits), 32'd0);

    // full entry from a clean start
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      check("entry_pos", {29'd0, entry_sel, byte_idx}, 32'(i));
      do_press(full_vec[i], 1'b0, i == 7);
    end
    check("full_reg_A", reg_A, 32'h2ac49214);
    check("full_reg_B", reg_B, 32'h6ac49214);
    check("full_pos", {29'd0, entry_sel, byte_idx}, 32'd0);

    // partial entry leaves committed operands alone
    for (int i = 0; i < 3; i++) do_press(8'hff, 1'b0, 1'b0);
    check("atom_reg_A", reg_A, 32'h2ac49214);
    check("atom_reg_B", reg_B, 32'h6ac49214);
    check("atom_byte_idx", {30'd0, byte_idx}, 32'd3);
    check("atom_entry_sel", {31'd0, entry_sel}, 32'd0);

    // reset after five presses, then a fresh entry
    for (int i = 0; i < 2; i++) do_press(8'hee, 1'b0, 1'b0);
    reset_dut();
    for (int i = 0; i < 8; i++) do_press(8'(i + 1), 1'b0, i == 7);
    check("rst_entry_reg_A", reg_A, 32'h01020304);
    check("rst_entry_reg_B", reg_B, 32'h05060708);

    // sw only matters on the press cycle
    for (int i = 0; i < 8; i++) do_press(8'((i + 1) * 8'h11), 1'b1, i == 7);
    check("swt_reg_A", reg_A, 32'h11223344);
    check("swt_reg_B", reg_B, 32'h55667788);

    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
